// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// legv8_ctrl_pkg
//   Shared encodings for the LEGv8 multicycle control FSM.
//   Revision: 1.0
// ============================================================================
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_BOOT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_R   = 4'd7,
    ST_WB_LD  = 4'd8,
    ST_CBZ    = 4'd9,
    ST_BRANCH = 4'd10,
    ST_TRAP   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    OC_RTYPE   = 3'd0,
    OC_LOAD    = 3'd1,
    OC_STORE   = 3'd2,
    OC_CBZ     = 3'd3,
    OC_B       = 3'd4,
    OC_ILLEGAL = 3'd5
  } opclass_t;

  localparam logic [10:0] C_OP_ADD      = 11'b10001011000;
  localparam logic [10:0] C_OP_SUB      = 11'b11001011000;
  localparam logic [10:0] C_OP_AND      = 11'b10001010000;
  localparam logic [10:0] C_OP_ORR      = 11'b10101010000;
  localparam logic [10:0] C_OP_LDUR     = 11'b11111000010;
  localparam logic [10:0] C_OP_STUR     = 11'b11111000000;
  localparam logic [10:0] C_OP_CBZ      = 11'b10110100000;
  localparam logic [10:0] C_OP_CBZ_MASK = 11'b11111111000;
  localparam logic [10:0] C_OP_B        = 11'b00010100000;
  localparam logic [10:0] C_OP_B_MASK   = 11'b11111100000;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_PASSB = 2'b01;
  localparam logic [1:0] C_ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] C_SRCB_REG  = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR = 2'b01;
  localparam logic [1:0] C_SRCB_DOFF = 2'b10;
  localparam logic [1:0] C_SRCB_BR   = 2'b11;

  // Registered per-state controls; gate_* / *_zero / *_ready flags are
  // later combined with the live mem_ready / zero / opcode inputs.
  typedef struct packed {
    logic [1:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_source;
    logic       illegal;
    logic       gate_fetch;
    logic       gate_decode;
    logic       pcw_always;
    logic       pcw_zero;
    logic       ret_always;
    logic       ret_ready;
  } ctl_t;

  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read   = 1'b1;
        c.alu_src_b  = C_SRCB_FOUR;
        c.aluop      = C_ALUOP_ADD;
        c.gate_fetch = 1'b1;
      end
      ST_DECODE: begin
        c.aluop       = C_ALUOP_ADD;
        c.alu_src_b   = C_SRCB_BR;
        c.gate_decode = 1'b1;
      end
      ST_EXEC_R: begin
        c.aluop     = C_ALUOP_RTYPE;
        c.alu_src_a = 1'b1;
        c.alu_src_b = C_SRCB_REG;
      end
      ST_WB_R: begin
        c.reg_write  = 1'b1;
        c.ret_always = 1'b1;
      end
      ST_ADDR: begin
        c.aluop     = C_ALUOP_ADD;
        c.alu_src_a = 1'b1;
        c.alu_src_b = C_SRCB_DOFF;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_WB_LD: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.ret_always = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        c.ret_ready = 1'b1;
      end
      ST_CBZ: begin
        c.aluop      = C_ALUOP_PASSB;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = C_SRCB_REG;
        c.pc_source  = 1'b1;
        c.pcw_zero   = 1'b1;
        c.ret_always = 1'b1;
      end
      ST_BRANCH: begin
        c.pc_source  = 1'b1;
        c.pcw_always = 1'b1;
        c.ret_always = 1'b1;
      end
      ST_TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// legv8_multicycle_control_if
//   Control/status bundle between the LEGv8 main control FSM and datapath.
//   Revision: 1.0
// ============================================================================
interface legv8_multicycle_control_if;
  logic [10:0] OpCode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        pc_source;
  logic        reg2loc;
  logic        mem_to_reg;
  logic        retire;
  logic        illegal;

  modport master (
    input  OpCode, zero, mem_ready,
    output ALUOp, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
           ir_write, pc_write, reg_write, pc_source, reg2loc, mem_to_reg,
           retire, illegal
  );

  modport slave (
    output OpCode, zero, mem_ready,
    input  ALUOp, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
           ir_write, pc_write, reg_write, pc_source, reg2loc, mem_to_reg,
           retire, illegal
  );
endinterface
`default_nettype wire

// File: rtl/legv8_opclass.sv
`default_nettype none
// ============================================================================
// legv8_opclass
//   Combinational classification of the 11-bit LEGv8 opcode.
//   Revision: 1.0
// ============================================================================
module legv8_opclass
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] i_opcode,
  output opclass_t    o_opclass
);

  always_comb begin
    o_opclass = OC_ILLEGAL;
    if (i_opcode == C_OP_ADD || i_opcode == C_OP_SUB ||
        i_opcode == C_OP_AND || i_opcode == C_OP_ORR)
      o_opclass = OC_RTYPE;
    else if (i_opcode == C_OP_LDUR)
      o_opclass = OC_LOAD;
    else if (i_opcode == C_OP_STUR)
      o_opclass = OC_STORE;
    else if ((i_opcode & C_OP_CBZ_MASK) == C_OP_CBZ)
      o_opclass = OC_CBZ;
    else if ((i_opcode & C_OP_B_MASK) == C_OP_B)
      o_opclass = OC_B;
  end

endmodule
`default_nettype wire

// File: rtl/legv8_multicycle_control.sv
`default_nettype none
// ============================================================================
// legv8_multicycle_control
//   Multicycle main control FSM for the LEGv8 datapath.
//   Revision: 1.0
// ============================================================================
module legv8_multicycle_control
  import legv8_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  legv8_multicycle_control_if.master   bus
);

  state_t   r_state;
  state_t   w_next;
  ctl_t     r_ctl;
  opclass_t w_class;

  legv8_opclass u_opclass (
    .i_opcode  (bus.OpCode),
    .o_opclass (w_class)
  );

  always_comb begin
    w_next = ST_BOOT;
    case (r_state)
      ST_BOOT:   w_next = ST_FETCH;
      ST_FETCH:  w_next = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (w_class)
          OC_RTYPE:          w_next = ST_EXEC_R;
          OC_LOAD, OC_STORE: w_next = ST_ADDR;
          OC_CBZ:            w_next = ST_CBZ;
          OC_B:              w_next = ST_BRANCH;
          default:           w_next = ST_TRAP;
        endcase
      end
      ST_EXEC_R: w_next = ST_WB_R;
      ST_WB_R:   w_next = ST_FETCH;
      ST_ADDR:   w_next = (w_class == OC_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: w_next = bus.mem_ready ? ST_WB_LD : ST_MEM_RD;
      ST_WB_LD:  w_next = ST_FETCH;
      ST_MEM_WR: w_next = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_CBZ:    w_next = ST_FETCH;
      ST_BRANCH: w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_BOOT;
    endcase
  end

  // Controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_ctl   <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_for(w_next);
    end
  end

  assign bus.ALUOp      = r_ctl.aluop;
  assign bus.alu_src_a  = r_ctl.alu_src_a;
  assign bus.alu_src_b  = r_ctl.alu_src_b;
  assign bus.mem_read   = r_ctl.mem_read;
  assign bus.mem_write  = r_ctl.mem_write;
  assign bus.i_or_d     = r_ctl.i_or_d;
  assign bus.reg_write  = r_ctl.reg_write;
  assign bus.mem_to_reg = r_ctl.mem_to_reg;
  assign bus.pc_source  = r_ctl.pc_source;
  assign bus.illegal    = r_ctl.illegal;

  assign bus.ir_write = r_ctl.gate_fetch & bus.mem_ready;
  assign bus.pc_write = (r_ctl.gate_fetch & bus.mem_ready) | r_ctl.pcw_always |
                        (r_ctl.pcw_zero & bus.zero);
  assign bus.reg2loc  = r_ctl.gate_decode &
                        ((w_class == OC_STORE) || (w_class == OC_CBZ));
  assign bus.retire   = r_ctl.ret_always | (r_ctl.ret_ready & bus.mem_ready);

endmodule
`default_nettype wire

// File: tb/tb_legv8_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_legv8_multicycle_control
//   Self-checking bench: directed table, corner sequences, random traffic.
//   Revision: 1.0
// ============================================================================
module tb_legv8_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ret_at = 0;

  legv8_multicycle_control_if bus();

  legv8_multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] C_ADD  = 11'b10001011000;
  localparam logic [10:0] C_SUB  = 11'b11001011000;
  localparam logic [10:0] C_AND  = 11'b10001010000;
  localparam logic [10:0] C_ORR  = 11'b10101010000;
  localparam logic [10:0] C_LDUR = 11'b11111000010;
  localparam logic [10:0] C_STUR = 11'b11111000000;

  // Observed vector: {ALUOp, src_a, src_b, mr, mw, iod, irw, pcw, rw, pcs, r2l, m2r, ret, ill}
  localparam logic [15:0] C_A_RT = 16'h8000;
  localparam logic [15:0] C_A_PB = 16'h4000;
  localparam logic [15:0] C_SA   = 16'h2000;
  localparam logic [15:0] C_SB4  = 16'h0800;
  localparam logic [15:0] C_SBD  = 16'h1000;
  localparam logic [15:0] C_SBB  = 16'h1800;
  localparam logic [15:0] C_MR   = 16'h0400;
  localparam logic [15:0] C_MW   = 16'h0200;
  localparam logic [15:0] C_IOD  = 16'h0100;
  localparam logic [15:0] C_IRW  = 16'h0080;
  localparam logic [15:0] C_PCW  = 16'h0040;
  localparam logic [15:0] C_RW   = 16'h0020;
  localparam logic [15:0] C_PCS  = 16'h0010;
  localparam logic [15:0] C_R2L  = 16'h0008;
  localparam logic [15:0] C_M2R  = 16'h0004;
  localparam logic [15:0] C_RET  = 16'h0002;
  localparam logic [15:0] C_ILL  = 16'h0001;

  logic [15:0] w_obs;
  assign w_obs = {bus.ALUOp, bus.alu_src_a, bus.alu_src_b, bus.mem_read,
                  bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                  bus.reg_write, bus.pc_source, bus.reg2loc, bus.mem_to_reg,
                  bus.retire, bus.illegal};

  typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_e;

  typedef struct {
    logic [10:0] op;
    int          fw;
    int          mw;
    logic        z;
    int          lat;
  } vec_t;

  function automatic kind_e kind_of(input logic [10:0] op);
    if (op == C_ADD || op == C_SUB || op == C_AND || op == C_ORR) return K_R;
    if (op == C_LDUR) return K_LD;
    if (op == C_STUR) return K_ST;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_vec(input string name, input logic [15:0] exp);
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL %s: outputs %b, expected %b", name, w_obs, exp);
    end
    checks++;
    if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
      errors++;
      $display("FAIL %s_rw_excl: mem_read=1 mem_write=1, expected not both", name);
    end
  endtask

  task automatic step(input string name, input logic rdy, input logic z,
                      input logic [15:0] exp);
    bus.mem_ready = rdy;
    bus.zero      = z;
    @(negedge clk);
    cyc++;
    if (bus.retire === 1'b1 && ret_at == 0) ret_at = cyc;
    check_vec(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check_vec(name, 16'h0000);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    #1;
    check_vec({name, "_hold"}, 16'h0000);
    rst = 1'b0;
    step({name, "_boot"}, 1'b1, 1'b1, 16'h0000);
  endtask

  // Expected cycle trace built from the instruction class and wait counts.
  task automatic run_instr(input logic [10:0] op, input int fw, input int mw,
                           input logic z, input int trap_cycles);
    kind_e k;
    k = kind_of(op);
    bus.OpCode = op;
    cyc    = 0;
    ret_at = 0;
    for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, rb(), C_MR | C_SB4);
    step("fetch", 1'b1, rb(), C_MR | C_SB4 | C_IRW | C_PCW);
    step("decode", rb(), rb(), C_SBB | ((k == K_ST || k == K_CBZ) ? C_R2L : 16'h0));
    case (k)
      K_R: begin
        step("exec_r", rb(), rb(), C_A_RT | C_SA);
        step("wb_r", rb(), rb(), C_RW | C_RET);
      end
      K_LD: begin
        step("addr_ld", rb(), rb(), C_SA | C_SBD);
        for (int i = 0; i < mw; i++) step("mem_rd_wait", 1'b0, rb(), C_MR | C_IOD);
        step("mem_rd", 1'b1, rb(), C_MR | C_IOD);
        step("wb_ld", rb(), rb(), C_RW | C_M2R | C_RET);
      end
      K_ST: begin
        step("addr_st", rb(), rb(), C_SA | C_SBD);
        for (int i = 0; i < mw; i++) step("mem_wr_wait", 1'b0, rb(), C_MW | C_IOD);
        step("mem_wr", 1'b1, rb(), C_MW | C_IOD | C_RET);
      end
      K_CBZ: step("cbz", rb(), z, C_A_PB | C_SA | C_PCS | C_RET | (z ? C_PCW : 16'h0));
      K_B:   step("branch", rb(), rb(), C_PCS | C_PCW | C_RET);
      default: begin
        for (int i = 0; i < trap_cycles; i++) step("trap", rb(), rb(), C_ILL);
      end
    endcase
  endtask

  function automatic int model_latency(input logic [10:0] op, input int fw, input int mw);
    case (kind_of(op))
      K_R:   return fw + 4;
      K_LD:  return fw + 5 + mw;
      K_ST:  return fw + 4 + mw;
      K_CBZ: return fw + 3;
      K_B:   return fw + 3;
      default: return 0;
    endcase
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{op: C_ADD,          fw: 0, mw: 0, z: 1'b0, lat: 4};
    tbl[1]  = '{op: C_LDUR,         fw: 0, mw: 2, z: 1'b0, lat: 7};
    tbl[2]  = '{op: 11'b10110100000, fw: 0, mw: 0, z: 1'b1, lat: 3};
    tbl[3]  = '{op: 11'b10110100000, fw: 0, mw: 0, z: 1'b0, lat: 3};
    tbl[4]  = '{op: C_STUR,         fw: 0, mw: 0, z: 1'b0, lat: 4};
    tbl[5]  = '{op: 11'b00010100000, fw: 0, mw: 0, z: 1'b0, lat: 3};
    tbl[6]  = '{op: C_SUB,          fw: 0, mw: 0, z: 1'b0, lat: 4};
    tbl[7]  = '{op: C_AND,          fw: 1, mw: 0, z: 1'b1, lat: 5};
    tbl[8]  = '{op: C_ORR,          fw: 0, mw: 0, z: 1'b0, lat: 4};
    tbl[9]  = '{op: C_STUR,         fw: 0, mw: 1, z: 1'b1, lat: 5};
    tbl[10] = '{op: 11'b10110100101, fw: 2, mw: 0, z: 1'b1, lat: 5};
    tbl[11] = '{op: 11'b00010111111, fw: 0, mw: 0, z: 1'b1, lat: 3};

    bus.OpCode    = 11'h000;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    #1;
    do_reset("reset");

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].z, 0);
      checks++;
      if (ret_at != tbl[i].lat) begin
        errors++;
        $display("FAIL table_lat[%0d]: retire at cycle %0d, expected %0d", i, ret_at, tbl[i].lat);
      end
    end

    // Reset asserted while a store is waiting on memory.
    bus.OpCode = C_STUR;
    step("rw_fetch", 1'b1, 1'b0, C_MR | C_SB4 | C_IRW | C_PCW);
    step("rw_decode", 1'b0, 1'b0, C_SBB | C_R2L);
    step("rw_addr", 1'b0, 1'b0, C_SA | C_SBD);
    bus.mem_ready = 1'b0;
    #2;
    check_vec("rw_memwr", C_MW | C_IOD);
    do_reset("rw_reset");
    step("rw_fetch_after", 1'b0, 1'b0, C_MR | C_SB4);

    // Unsupported opcode traps until reset.
    run_instr(11'b11111111111, 0, 0, 1'b0, 10);
    do_reset("trap_reset");

    for (int n = 0; n < 200; n++) begin
      logic [10:0] op;
      int fw;
      int mw;
      case ($urandom_range(0, 8))
        0: op = C_ADD;
        1: op = C_SUB;
        2: op = C_AND;
        3: op = C_ORR;
        4: op = C_LDUR;
        5: op = C_STUR;
        6: op = {8'b10110100, 3'($urandom_range(0, 7))};
        7: op = {6'b000101, 5'($urandom_range(0, 31))};
        default: op = 11'($urandom);
      endcase
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      run_instr(op, fw, mw, rb(), 3);
      if (kind_of(op) == K_ILL) begin
        do_reset("rand_trap_reset");
      end else begin
        checks++;
        if (ret_at != model_latency(op, fw, mw)) begin
          errors++;
          $display("FAIL rand_lat op=%b: retire at cycle %0d, expected %0d",
                   op, ret_at, model_latency(op, fw, mw));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/legv8_multicycle_control.md
# legv8_multicycle_control

Multicycle main control FSM for the LEGv8 datapath. Decodes the 11-bit instruction opcode and sequences fetch, decode, execute, memory and write-back over several cycles. Drives the 2-bit `ALUOp` consumed by `ALU_Control`, along with all datapath enables and muxes. Handles a ready-based memory handshake and traps on unsupported opcodes.

## Interface
Parameters:
- none; encodings are fixed in `legv8_ctrl_pkg`.

Ports:
- Clock and reset: one clock (`clk`); reset `rst` is asynchronous and active-high.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `OpCode` in 11: instruction bits [31:21], taken from the IR; valid from DECODE onward.
- `zero` in 1: ALU zero flag; sampled in CBZ.
- `mem_ready` in 1: memory has completed the current read/write this cycle.
- `ALUOp` out 2: 00 add; 01 pass B; 10 R-type function (resolved by `ALU_Control`).
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended D-offset, 11 = branch offset << 2.
- `mem_read`, `mem_write` out 1: memory request, held until `mem_ready`.
- `i_or_d` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write` out 1: register enables.
- `pc_source` out 1: 0 = ALU result (PC+4), 1 = branch target.
- `reg2loc`, `mem_to_reg` out 1: register-file read-select and write-data select.
- `retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal` out 1: sticky trap indicator.

## Operation
- States: BOOT, FETCH, DECODE, EXEC_R, ADDR, MEM_RD, MEM_WR, WB_R, WB_LD, CBZ, BRANCH, TRAP.
- Reset: state = BOOT and every output = 0.
- BOOT: all outputs 0; moves to FETCH unconditionally.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ALUOp`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when it is 1.
- DECODE: `ALUOp`=00, `alu_src_b`=11 (branch target precomputed); `reg2loc`=1 for STUR/CBZ. Next state by opcode class:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000) -> EXEC_R.
  - LDUR 11111000010 or STUR 11111000000 -> ADDR.
  - CBZ 10110100xxx -> CBZ.
  - B 000101xxxxx -> BRANCH.
  - any other opcode -> TRAP.
- EXEC_R: `ALUOp`=10, `alu_src_a`=1, `alu_src_b`=00 -> WB_R.
- WB_R: `reg_write`=1, `mem_to_reg`=0, `retire`=1 -> FETCH.
- ADDR: `ALUOp`=00, `alu_src_a`=1, `alu_src_b`=10 -> MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: `mem_read`=1, `i_or_d`=1; waits for `mem_ready` -> WB_LD.
- WB_LD: `reg_write`=1, `mem_to_reg`=1, `retire`=1 -> FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1; `retire`=`mem_ready`; on `mem_ready` -> FETCH.
- CBZ: `ALUOp`=01, `alu_src_a`=1, `alu_src_b`=00, `pc_source`=1, `pc_write`=`zero`, `retire`=1 -> FETCH.
- BRANCH: `pc_source`=1, `pc_write`=1, `retire`=1 -> FETCH.
- TRAP: `illegal`=1, all other outputs 0; remains in TRAP until `rst`.
- Outputs not listed for a state are 0. All outputs are Moore functions of state, except the `mem_ready`/`zero` gating stated above.

## Timing
- Latency with zero-wait memory (`mem_ready` high on the first request cycle), counted from FETCH entry to the `retire` cycle inclusive:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
  - B: 3 cycles.
- Each memory wait cycle adds 1 cycle; `mem_read`/`mem_write` stay stable while waiting.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- `mem_read` and `mem_write` are never asserted together.
- Reset asserted mid-instruction: outputs go to 0 asynchronously and state goes to BOOT; no partial `reg_write` or `pc_write`.
- First FETCH request appears 1 cycle after reset deassertion.

## Structure
- `legv8_ctrl_pkg` holds:
  - the state enum;
  - opcode constants/masks (ADD, SUB, AND, ORR, LDUR, STUR, CBZ, B);
  - ALUOp constants (ADD=00, PASSB=01, RTYPE=10);
  - `alu_src_b` select constants.
- Sub-module `legv8_opclass`: combinational classification of `OpCode` into {RTYPE, LOAD, STORE, CBZ, B, ILLEGAL}, used by DECODE and ADDR.

## Test plan
- ADD (10001011000), `mem_ready` tied 1 -> states FETCH, DECODE, EXEC_R, WB_R; `ALUOp`=10 in EXEC_R; `reg_write`=1 and `retire`=1 in cycle 4.
- LDUR (11111000010) with `mem_ready` delayed 2 cycles in MEM_RD -> `mem_read`/`i_or_d`=1 held 3 cycles; WB_LD has `mem_to_reg`=1; retires after 7 cycles.
- CBZ (10110100000):
  - `zero`=1 -> `ALUOp`=01, `pc_write`=1, `pc_source`=1.
  - repeated with `zero`=0 -> `pc_write`=0, back to FETCH.
- Opcode 11111111111 -> TRAP; `illegal`=1 stays high for 10 cycles regardless of inputs; `rst` clears it to 0 with state BOOT.
- `rst` pulsed during MEM_WR -> `mem_write` drops to 0 immediately; BOOT, then FETCH with `mem_read`=1 one cycle after release.
- Back-to-back STUR, B, SUB -> 4+3+4 `retire` pulses at expected cycles; `mem_read` and `mem_write` never both 1.
